// File: rtl/arbt_pkg.sv
// Shared constants and grant-decode helpers for the arbiter grant mux.
package arbt_pkg;

  localparam int NPORT = 4;
  localparam int ID_W  = 2;

  // Occupancy is {out_vld, pend_vld}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } occ_e;

  function automatic logic [ID_W-1:0] oh2idx(input logic [NPORT-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [NPORT-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NPORT; i++) begin
      n += int'(v[i]);
    end
    return n > 1;
  endfunction

endpackage

// File: rtl/arbt_timeout_cnt.sv
// Stall counter: asserts expire on the stalled cycle that reaches TIMEOUT-1.
module arbt_timeout_cnt #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam bit              ENABLED = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] LAST    = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !ENABLED) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expire = ENABLED && en && (cnt == LAST);

endmodule

// File: rtl/arbt_gnt_mux.sv
// Captures the granted requester's payload into a 1-deep output stage plus a
// 1-deep pending slot and delivers it over valid/ready with ack, timeout and sticky errors.
module arbt_gnt_mux
  import arbt_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            gnt0,
  input  logic            gnt1,
  input  logic            gnt2,
  input  logic            gnt3,
  input  logic [DW-1:0]   din0,
  input  logic [DW-1:0]   din1,
  input  logic [DW-1:0]   din2,
  input  logic [DW-1:0]   din3,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   out_data,
  output logic [ID_W-1:0] out_id,
  output logic            ack0,
  output logic            ack1,
  output logic            ack2,
  output logic            ack3,
  output logic            drop_pls,
  output logic            busy,
  output logic            err_multi,
  output logic            err_ovf,
  output logic            err_to,
  input  logic            err_clr
);

  logic [NPORT-1:0] gnt_v;
  logic             g_multi;
  logic             g_ok;
  logic [ID_W-1:0]  g_idx;
  logic [DW-1:0]    g_data;

  logic             pend_vld;
  logic [DW-1:0]    pend_data;
  logic [ID_W-1:0]  pend_id;

  logic             hs;
  logic             expire;
  logic             adv;
  logic             ovf_set;
  logic [NPORT-1:0] ack_p1;
  occ_e             occ;

  // Grant decode
  assign gnt_v   = {gnt3, gnt2, gnt1, gnt0};
  assign g_multi = multi_hot(gnt_v);
  assign g_ok    = (gnt_v != '0) && !g_multi;
  assign g_idx   = oh2idx(gnt_v);

  always_comb begin
    g_data = din0;
    case (g_idx)
      2'd0:    g_data = din0;
      2'd1:    g_data = din1;
      2'd2:    g_data = din2;
      default: g_data = din3;
    endcase
  end

  assign occ     = occ_e'({out_vld, pend_vld});
  assign hs      = out_vld & out_rdy;
  // A timed-out beat leaves the output stage exactly like a delivered one.
  assign adv     = hs | expire;
  assign ovf_set = (occ == ST_TWO) && !adv && g_ok;
  assign busy    = out_vld | pend_vld;

  arbt_timeout_cnt #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (out_vld & ~out_rdy),
    .clr    (adv | ~out_vld),
    .expire (expire)
  );

  // Output / pending stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      pend_id   <= '0;
    end else begin
      case (occ)
        ST_EMPTY: begin
          if (g_ok) begin
            out_vld  <= 1'b1;
            out_data <= g_data;
            out_id   <= g_idx;
          end
        end
        ST_ONE: begin
          if (adv) begin
            if (g_ok) begin
              out_data <= g_data;
              out_id   <= g_idx;
            end else begin
              out_vld <= 1'b0;
            end
          end else if (g_ok) begin
            pend_vld  <= 1'b1;
            pend_data <= g_data;
            pend_id   <= g_idx;
          end
        end
        ST_TWO: begin
          if (adv) begin
            out_data <= pend_data;
            out_id   <= pend_id;
            if (g_ok) begin
              pend_data <= g_data;
              pend_id   <= g_idx;
            end else begin
              pend_vld <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Ack / drop pulses and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_p1    <= '0;
      drop_pls  <= 1'b0;
      err_multi <= 1'b0;
      err_ovf   <= 1'b0;
      err_to    <= 1'b0;
    end else begin
      ack_p1    <= hs ? (NPORT'(1) << out_id) : '0;
      drop_pls  <= expire;
      err_multi <= g_multi | (err_multi & ~err_clr);
      err_ovf   <= ovf_set | (err_ovf & ~err_clr);
      err_to    <= expire  | (err_to & ~err_clr);
    end
  end

  assign ack0 = ack_p1[0];
  assign ack1 = ack_p1[1];
  assign ack2 = ack_p1[2];
  assign ack3 = ack_p1[3];

endmodule

// File: tb/tb_arbt_gnt_mux.sv
// Randomized + directed bench for arbt_gnt_mux against a queue-based reference model.
module tb_arbt_gnt_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  gnt;
  logic [31:0] din [4];
  logic        out_rdy;
  logic        err_clr;

  logic        a_vld, b_vld, a_drop, b_drop, a_busy, b_busy;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_id, b_id;
  logic [3:0]  a_ack, b_ack;
  logic        a_em, a_eo, a_et, b_em, b_eo, b_et;

  int total = 0;
  int bad   = 0;

  arbt_gnt_mux #(.DW(32), .TO_W(8), .TIMEOUT(200)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .out_vld(a_vld), .out_rdy(out_rdy), .out_data(a_data), .out_id(a_id),
    .ack0(a_ack[0]), .ack1(a_ack[1]), .ack2(a_ack[2]), .ack3(a_ack[3]),
    .drop_pls(a_drop), .busy(a_busy),
    .err_multi(a_em), .err_ovf(a_eo), .err_to(a_et), .err_clr(err_clr)
  );

  arbt_gnt_mux #(.DW(32), .TO_W(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .out_vld(b_vld), .out_rdy(out_rdy), .out_data(b_data), .out_id(b_id),
    .ack0(b_ack[0]), .ack1(b_ack[1]), .ack2(b_ack[2]), .ack3(b_ack[3]),
    .drop_pls(b_drop), .busy(b_busy),
    .err_multi(b_em), .err_ovf(b_eo), .err_to(b_et), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-DUT list of queued beats {id, data}, at most two deep.
  int          tov   [2] = '{200, 4};
  int          mcnt  [2];
  logic [33:0] mq    [2][2];
  int          stall [2];
  logic [3:0]  mack  [2];
  logic        mdrop [2];
  logic [2:0]  merr  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; stall[m] = 0; mack[m] = '0; mdrop[m] = 1'b0; merr[m] = '0;
      mq[m][0] = '0; mq[m][1] = '0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      bit  vld, hs, exp, pop;
      int  n, idx;
      vld = (mcnt[m] > 0);
      hs  = vld && out_rdy;
      exp = (tov[m] != 0) && vld && !out_rdy && (stall[m] == tov[m] - 1);
      pop = hs || exp;
      n   = $countones(gnt);
      idx = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
      mack[m]  = hs ? (4'b0001 << mq[m][0][33:32]) : 4'b0000;
      mdrop[m] = exp;
      merr[m]  = (merr[m] & ~{3{err_clr}}) |
                 {n > 1, (n == 1) && (mcnt[m] == 2) && !pop, exp};
      stall[m] = (vld && !out_rdy && !exp) ? stall[m] + 1 : 0;
      if (pop) begin
        mq[m][0] = mq[m][1];
        mcnt[m]--;
      end
      if (n == 1 && mcnt[m] < 2) begin
        mq[m][mcnt[m]] = {2'(idx), din[idx]};
        mcnt[m]++;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec(input int m);
    logic v;
    v = (mcnt[m] > 0);
    return 64'({v, v ? mq[m][0][33:32] : 2'b00, v ? mq[m][0][31:0] : 32'h0,
                mack[m], mdrop[m], v, merr[m]});
  endfunction

  function automatic logic [63:0] dut_vec(input logic v, input logic [1:0] id,
                                          input logic [31:0] d, input logic [3:0] ak,
                                          input logic dr, input logic bs, input logic [2:0] e);
    return 64'({v, v ? id : 2'b00, v ? d : 32'h0, ak, dr, bs, e});
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("a_cyc", dut_vec(a_vld, a_id, a_data, a_ack, a_drop, a_busy, {a_em, a_eo, a_et}), exp_vec(0));
    check("b_cyc", dut_vec(b_vld, b_id, b_data, b_ack, b_drop, b_busy, {b_em, b_eo, b_et}), exp_vec(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; gnt = '0; out_rdy = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    model_reset();
    repeat (3) cycle();
    check("rst_state", {a_vld, a_data, a_id, a_ack, a_drop, a_busy, a_em, a_eo, a_et}, '0);
    rst_n = 1'b1;

    // T1 single beat
    out_rdy = 1'b1; gnt = 4'b0100; din[2] = 32'hA5A5_0002;
    cycle(); gnt = '0;
    check("t1_beat", {a_vld, a_id, a_data}, {1'b1, 2'd2, 32'hA5A5_0002});
    cycle();
    check("t1_ack", {a_vld, a_ack}, {1'b0, 4'b0100});
    cycle();
    check("t1_ack_end", a_ack, 4'b0000);

    // T2 stall with a pending beat
    out_rdy = 1'b0; gnt = 4'b0001; din[0] = 32'h1111_0000;
    cycle(); gnt = '0;
    cycle(); gnt = 4'b1000; din[3] = 32'h3333_0003;
    cycle(); gnt = '0;
    cycle(); cycle();
    check("t2_hold", {a_vld, a_id, a_data, a_busy}, {1'b1, 2'd0, 32'h1111_0000, 1'b1});
    out_rdy = 1'b1;
    cycle();
    check("t2_beat3", {a_vld, a_id, a_data, a_ack}, {1'b1, 2'd3, 32'h3333_0003, 4'b0001});
    cycle();
    check("t2_ack3", {a_vld, a_ack}, {1'b0, 4'b1000});
    cycle();

    // T3 overflow
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    out_rdy = 1'b0;
    gnt = 4'b0010; din[1] = 32'h0000_0011; cycle();
    gnt = 4'b0100; din[2] = 32'h0000_0022; cycle();
    gnt = 4'b0001; din[0] = 32'h0000_0033; cycle();
    gnt = '0;
    check("t3_ovf", a_eo, 1'b1);
    out_rdy = 1'b1;
    cycle();
    check("t3_second", {a_vld, a_id, a_ack}, {1'b1, 2'd2, 4'b0010});
    cycle();
    check("t3_empty", {a_vld, a_ack}, {1'b0, 4'b0100});
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    check("t3_clr", a_eo, 1'b0);

    // T4 multiple grants
    gnt = 4'b1001; cycle(); gnt = '0;
    check("t4_multi", {a_em, a_vld}, {1'b1, 1'b0});
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    check("t4_clr", a_em, 1'b0);

    // T5 timeout on the TIMEOUT=4 instance
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    out_rdy = 1'b0; gnt = 4'b0010; din[1] = 32'h5555_0001;
    cycle(); gnt = '0;
    n = 0;
    while (b_vld && n < 20) begin
      n++;
      cycle();
    end
    check("t5_vld_len", 64'(n), 64'd4);
    check("t5_drop", {b_drop, b_et, b_ack}, {1'b1, 1'b1, 4'b0000});
    cycle();
    check("t5_drop_end", {b_drop, b_ack, b_vld}, '0);
    out_rdy = 1'b1; repeat (3) cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;

    // T6 asynchronous reset while two beats are held
    out_rdy = 1'b0;
    gnt = 4'b0001; cycle();
    gnt = 4'b1000; cycle();
    gnt = '0;
    check("t6_two", {a_vld, a_busy}, {1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", {a_vld, a_data, a_id, a_ack, a_drop, a_busy, a_em, a_eo, a_et}, '0);
    model_reset();
    cycle(); cycle();
    rst_n = 1'b1; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t6_no_ack", {a_ack, a_vld}, '0);
    end

    // Randomized traffic, including one long stall to exercise the 200-cycle timeout
    for (int c = 0; c < 2500; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       gnt = 4'b0001 << r;
      else if (r == 4) gnt = 4'((1 << $urandom_range(0, 1)) | (4 << $urandom_range(0, 1)));
      else             gnt = '0;
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      if (c >= 1000 && c < 1210) out_rdy = 1'b0;
      else                       out_rdy = ($urandom_range(0, 9) < 6);
      err_clr = ($urandom_range(0, 49) == 0);
      if (c >= 1000 && c < 1210 && c > 1003) gnt = '0;
      cycle();
    end
    gnt = '0; err_clr = 1'b0; out_rdy = 1'b1;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
